// File: rtl/aoi222_bist_ctrl.sv
`timescale 1ns/1ps
// Built-in self-test sequencer for a single AOI222 cell (Z = ~(AB | CD | EF)).
// The sequencer sweeps all 64 input patterns onto the cell. Each pattern is held
// for SETTLE cycles and is then sampled in one CAPTURE cycle. The returned Z is
// compared against a golden model and compacted into a MISR. The block counts
// mismatches and records the first failing pattern.
module aoi222_bist_ctrl #(
    parameter int              SETTLE = 2,
    parameter int              SIG_W  = 16,
    parameter logic [SIG_W-1:0] POLY  = 16'h1021,
    parameter int              CNT_W  = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    output logic [5:0]       pat,
    input  logic             z_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [CNT_W-1:0] fail_cnt,
    output logic [5:0]       first_fail,
    output logic [SIG_W-1:0] signature
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        APPLY   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t           state, state_next;
    logic [5:0]       pat_next;
    logic [3:0]       settle_cnt, settle_next;
    logic [CNT_W-1:0] fail_next;
    logic [5:0]       first_next;
    logic [SIG_W-1:0] sig, sig_next;
    logic             exp_z;
    logic             miss;

    // Golden AOI222 response for one input pattern (A = bit 0 ... F = bit 5).
    function automatic logic aoi222(input logic [5:0] p);
        return ~((p[0] & p[1]) | (p[2] & p[3]) | (p[4] & p[5]));
    endfunction

    // Increment that sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_W'(1);
    endfunction

    // One MISR step: shift left, fold the feedback polynomial in when the MSB
    // falls out, and inject the captured bit at the LSB.
    function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] s,
                                                   input logic             b);
        return {s[SIG_W-2:0], 1'b0}
             ^ (s[SIG_W-1] ? POLY : {SIG_W{1'b0}})
             ^ {{(SIG_W-1){1'b0}}, b};
    endfunction

    assign exp_z = aoi222(pat);
    assign miss  = (z_in != exp_z);

    // State and datapath registers; every one of them is cleared by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            pat        <= 6'd0;
            settle_cnt <= 4'd0;
            fail_cnt   <= '0;
            first_fail <= 6'd0;
            sig        <= '0;
        end else begin
            state      <= state_next;
            pat        <= pat_next;
            settle_cnt <= settle_next;
            fail_cnt   <= fail_next;
            first_fail <= first_next;
            sig        <= sig_next;
        end
    end

    // Next-state and next-datapath logic. Abort overrides start. pat only
    // advances on CAPTURE->APPLY, so the cell inputs stay stable while Z is sampled.
    always_comb begin
        state_next  = state;
        pat_next    = pat;
        settle_next = settle_cnt;
        fail_next   = fail_cnt;
        first_next  = first_fail;
        sig_next    = sig;
        if (abort) begin
            // Partial results are deliberately left in place for inspection.
            state_next  = IDLE;
            pat_next    = 6'd0;
            settle_next = 4'd0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_next  = APPLY;
                        pat_next    = 6'd0;
                        settle_next = 4'd0;
                        fail_next   = '0;
                        first_next  = 6'd0;
                        sig_next    = '0;
                    end
                end
                APPLY: begin
                    settle_next = settle_cnt + 4'd1;
                    if (settle_cnt == 4'(SETTLE - 1))
                        state_next = CAPTURE;
                end
                CAPTURE: begin
                    if (miss) begin
                        fail_next = sat_inc(fail_cnt);
                        // The counter saturates and never wraps, so zero means no
                        // mismatch has been seen yet.
                        if (fail_cnt == '0)
                            first_next = pat;
                    end
                    sig_next = misr_step(sig, z_in);
                    if (pat == 6'd63) begin
                        state_next = DONE;
                    end else begin
                        pat_next    = pat + 6'd1;
                        settle_next = 4'd0;
                        state_next  = APPLY;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    assign busy      = (state == APPLY) || (state == CAPTURE);
    assign done      = (state == DONE);
    assign pass      = done && (fail_cnt == '0);
    assign signature = sig;

endmodule

// File: tb/tb_aoi222_bist_ctrl.sv
`timescale 1ns/1ps
// Self-checking bench for aoi222_bist_ctrl. A default instance and a CNT_W=4
// instance run side by side. The same z source model feeds both instances. The
// expected results come from a pattern-by-pattern model of the sweep.
module tb_aoi222_bist_ctrl;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [5:0]  pat, pat2;
    logic        z_in, z2;
    logic        busy, done, pass, busy2, done2, pass2;
    logic [6:0]  fail_cnt;
    logic [3:0]  fail_cnt2;
    logic [5:0]  first_fail, first_fail2;
    logic [15:0] signature, signature2;

    int          mode;      // 0 good cell, 1 stuck-at-0, 2 stuck-at-1, 3 random fault mask
    logic [63:0] mask;
    int          checks   = 0;
    int          failures = 0;
    logic [15:0] golden_sig;

    always #5 clk = ~clk;

    function automatic logic aoi(input logic [5:0] p);
        return ~((p[0] & p[1]) | (p[2] & p[3]) | (p[4] & p[5]));
    endfunction

    function automatic logic zsrc(input int md, input logic [63:0] mk, input logic [5:0] p);
        case (md)
            0:       return aoi(p);
            1:       return 1'b0;
            2:       return 1'b1;
            default: return aoi(p) ^ mk[p];
        endcase
    endfunction

    assign z_in = zsrc(mode, mask, pat);
    assign z2   = zsrc(mode, mask, pat2);

    aoi222_bist_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pat(pat), .z_in(z_in),
        .busy(busy), .done(done), .pass(pass), .fail_cnt(fail_cnt),
        .first_fail(first_fail), .signature(signature)
    );

    aoi222_bist_ctrl #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .pat(pat2), .z_in(z2),
        .busy(busy2), .done(done2), .pass(pass2), .fail_cnt(fail_cnt2),
        .first_fail(first_fail2), .signature(signature2)
    );

    // Whole-sweep reference: walk the 64 patterns in order, score each response
    // against the true AOI222 value and fold it into the signature.
    task automatic model_run(input int md, input logic [63:0] mk, input int cw,
                             output int ecnt, output int efirst, output logic [15:0] esig);
        logic zb;
        ecnt = 0; efirst = 0; esig = 16'h0;
        for (int p = 0; p < 64; p++) begin
            zb = zsrc(md, mk, 6'(p));
            if (zb != aoi(6'(p))) begin
                if (ecnt == 0) efirst = p;
                if (ecnt < (1 << cw) - 1) ecnt++;
            end
            esig = {esig[14:0], 1'b0} ^ (esig[15] ? 16'h1021 : 16'h0) ^ {15'h0, zb};
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_done(output int n);
        n = 0;
        while (busy && n < 2000) begin
            n++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 0; mask = '0;
        tick(); tick();
        checks++;
        if ({pat, busy, done, pass, fail_cnt, first_fail, signature} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got pat=%0d busy=%b done=%b pass=%b cnt=%0d first=%0d sig=%h exp all zero",
                     pat, busy, done, pass, fail_cnt, first_fail, signature);
        end
        checks++;
        if ({pat2, busy2, done2, pass2, fail_cnt2, first_fail2, signature2} !== '0) begin
            failures++;
            $display("FAIL reset_outputs_cnt4 got pat=%0d busy=%b done=%b cnt=%0d sig=%h exp all zero",
                     pat2, busy2, done2, fail_cnt2, signature2);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_good_sweep();
        int n, ec, ef;
        logic [15:0] es;
        mode = 0;
        model_run(0, '0, 7, ec, ef, es);
        golden_sig = es;
        pulse_start();
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            failures++; $display("FAIL good_busy_rise got busy=%b done=%b exp busy=1 done=0", busy, done);
        end
        run_to_done(n);
        checks++;
        if (n != 192) begin failures++; $display("FAIL good_busy_cycles got=%0d exp=192", n); end
        checks++;
        if (done !== 1'b1 || pass !== 1'b1) begin
            failures++; $display("FAIL good_done_pass got done=%b pass=%b exp 1 1", done, pass);
        end
        checks++;
        if (fail_cnt !== 7'd0 || first_fail !== 6'd0) begin
            failures++; $display("FAIL good_counts got cnt=%0d first=%0d exp 0 0", fail_cnt, first_fail);
        end
        checks++;
        if (signature !== golden_sig) begin
            failures++; $display("FAIL good_signature got=%h exp=%h", signature, golden_sig);
        end
        checks++;
        if (pat !== 6'd63) begin failures++; $display("FAIL good_pat_held got=%0d exp=63", pat); end
        // Results must hold stable in DONE.
        repeat (5) tick();
        checks++;
        if (done !== 1'b1 || fail_cnt !== 7'd0 || signature !== golden_sig) begin
            failures++; $display("FAIL good_hold got done=%b sig=%h exp done=1 sig=%h", done, signature, golden_sig);
        end
    endtask

    task automatic test_stuck0();
        int n, ec, ef;
        logic [15:0] es;
        mode = 1;
        model_run(1, '0, 7, ec, ef, es);
        pulse_start();
        run_to_done(n);
        checks++;
        if (done !== 1'b1 || pass !== 1'b0) begin
            failures++; $display("FAIL sa0_done_pass got done=%b pass=%b exp 1 0", done, pass);
        end
        checks++;
        if (fail_cnt !== 7'd27 || first_fail !== 6'd0) begin
            failures++; $display("FAIL sa0_counts got cnt=%0d first=%0d exp 27 0", fail_cnt, first_fail);
        end
        checks++;
        if (signature !== es || signature === golden_sig) begin
            failures++; $display("FAIL sa0_signature got=%h exp=%h (golden %h)", signature, es, golden_sig);
        end
    endtask

    task automatic test_stuck1();
        int n, ec, ef;
        logic [15:0] es;
        mode = 2;
        model_run(2, '0, 7, ec, ef, es);
        pulse_start();
        run_to_done(n);
        checks++;
        if (fail_cnt !== 7'd37 || first_fail !== 6'd3 || pass !== 1'b0) begin
            failures++; $display("FAIL sa1_counts got cnt=%0d first=%0d pass=%b exp 37 3 0", fail_cnt, first_fail, pass);
        end
        checks++;
        if (signature !== es) begin failures++; $display("FAIL sa1_signature got=%h exp=%h", signature, es); end
        checks++;
        if (fail_cnt2 !== 4'd15 || done2 !== 1'b1 || pass2 !== 1'b0 || first_fail2 !== 6'd3) begin
            failures++; $display("FAIL sa1_saturate_cnt4 got cnt=%0d done=%b pass=%b first=%0d exp 15 1 0 3",
                                 fail_cnt2, done2, pass2, first_fail2);
        end
    endtask

    task automatic test_random_faults();
        int n, ec, ef, ec4, ef4;
        logic [15:0] es, es4;
        for (int it = 0; it < 4; it++) begin
            mask = {$urandom, $urandom};
            if (it == 0) mask = 64'h1 << $urandom_range(63);
            mode = 3;
            model_run(3, mask, 7, ec, ef, es);
            model_run(3, mask, 4, ec4, ef4, es4);
            pulse_start();
            run_to_done(n);
            checks++;
            if (fail_cnt !== 7'(ec) || first_fail !== 6'(ef) || pass !== (ec == 0)) begin
                failures++; $display("FAIL rand_counts it=%0d got cnt=%0d first=%0d pass=%b exp %0d %0d %b",
                                     it, fail_cnt, first_fail, pass, ec, ef, (ec == 0));
            end
            checks++;
            if (signature !== es) begin failures++; $display("FAIL rand_signature it=%0d got=%h exp=%h", it, signature, es); end
            checks++;
            if (fail_cnt2 !== 4'(ec4) || signature2 !== es4) begin
                failures++; $display("FAIL rand_cnt4 it=%0d got cnt=%0d sig=%h exp %0d %h", it, fail_cnt2, signature2, ec4, es4);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n;
        mode = 0;
        // Entered from DONE of the previous sweep: done must fall as busy rises.
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL b2b_precond got done=%b exp 1", done); end
        pulse_start();
        checks++;
        if (done !== 1'b0 || busy !== 1'b1 || pat !== 6'd0 || fail_cnt !== 7'd0) begin
            failures++; $display("FAIL b2b_restart got done=%b busy=%b pat=%0d cnt=%0d exp 0 1 0 0", done, busy, pat, fail_cnt);
        end
        run_to_done(n);
        checks++;
        if (n != 192 || pass !== 1'b1 || signature !== golden_sig) begin
            failures++; $display("FAIL b2b_result got cycles=%0d pass=%b sig=%h exp 192 1 %h", n, pass, signature, golden_sig);
        end
    endtask

    task automatic test_abort();
        int n;
        mode = 0;
        pulse_start();
        repeat (49) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || pat !== 6'd0) begin
            failures++; $display("FAIL abort_idle got busy=%b done=%b pat=%0d exp 0 0 0", busy, done, pat);
        end
        tick();
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL abort_stays_idle got busy=%b exp 0", busy); end
        pulse_start();
        run_to_done(n);
        checks++;
        if (n != 192 || pass !== 1'b1 || fail_cnt !== 7'd0 || signature !== golden_sig) begin
            failures++; $display("FAIL abort_then_sweep got cycles=%0d pass=%b cnt=%0d sig=%h exp 192 1 0 %h",
                                 n, pass, fail_cnt, signature, golden_sig);
        end
    endtask

    task automatic test_start_ignored();
        int n;
        mode = 0;
        pulse_start();
        repeat (20) tick();
        pulse_start();
        // 21 cycles after the first start the sweep is on pattern 21/3 = 7.
        checks++;
        if (busy !== 1'b1 || pat !== 6'd7) begin
            failures++; $display("FAIL busy_start_ignored got busy=%b pat=%0d exp 1 7", busy, pat);
        end
        run_to_done(n);
        checks++;
        if (n != 171 || pass !== 1'b1) begin
            failures++; $display("FAIL busy_start_timing got remaining=%0d pass=%b exp 171 1", n, pass);
        end
    endtask

    task automatic test_rst_mid_sweep();
        mode = 2;
        pulse_start();
        repeat (60) tick();
        pulse_start();
        repeat (38) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({pat, busy, done, pass, fail_cnt, first_fail, signature} !== '0) begin
            failures++; $display("FAIL rst_mid got pat=%0d busy=%b done=%b cnt=%0d first=%0d sig=%h exp all zero",
                                 pat, busy, done, fail_cnt, first_fail, signature);
        end
        checks++;
        if ({pat2, busy2, done2, fail_cnt2, signature2} !== '0) begin
            failures++; $display("FAIL rst_mid_cnt4 got pat=%0d busy=%b cnt=%0d sig=%h exp all zero",
                                 pat2, busy2, fail_cnt2, signature2);
        end
        tick();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            failures++; $display("FAIL rst_mid_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_good_sweep();
        test_stuck0();
        test_stuck1();
        test_random_faults();
        test_back_to_back();
        test_abort();
        test_start_ignored();
        test_rst_mid_sweep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
